// File: rtl/sprite_capture.sv
`default_nettype none
// ============================================================================
// Module   : sprite_capture
// Brief    : Deserializes a sprite renderer's serial gfx stream into 8-bit rows
//            for a sprite RAM, with an optional left/right mirror check.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_capture #(
  parameter int HEIGHT = 16,
  parameter int MIRROR = 1,
  parameter int LAG    = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vstart,
  input  logic       hstart,
  input  logic       gfx,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       mirror_err,
  output logic       frame_done,
  output logic       busy
);

  localparam logic [3:0] c_last_px   = (MIRROR != 0) ? 4'd15 : 4'd7;
  localparam logic [3:0] c_last_row  = 4'(HEIGHT - 1);
  localparam logic [3:0] c_last_skip = (LAG > 0) ? 4'(LAG - 1) : 4'd0;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT_H = 3'd1;
  localparam logic [2:0] S_SKIP   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [3:0] r_row;
  logic [3:0] r_cnt;
  logic [7:0] r_shift;

  logic       w_restart;
  logic       w_last_px;
  logic       w_write;
  logic       w_mis;
  logic [2:0] w_mir_idx;

  logic       w_wr_en_nxt;
  logic [3:0] w_addr_nxt;
  logic [7:0] w_data_nxt;
  logic       w_err_nxt;
  logic       w_fd_nxt;
  logic       w_busy_nxt;

  // vstart restarts the frame from any state except DONE; it beats the final-sample write
  assign w_restart = vstart && (r_state != S_DONE);
  assign w_last_px = (r_state == S_SHIFT) && (r_cnt == c_last_px);
  assign w_write   = w_last_px && !vstart;
  assign w_mir_idx = 3'(4'd15 - r_cnt);
  assign w_mis     = (r_state == S_SHIFT) && r_cnt[3] && (gfx != r_shift[w_mir_idx]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (vstart) w_state_nxt = S_WAIT_H;
      end
      S_WAIT_H: begin
        if (vstart)      w_state_nxt = S_WAIT_H;
        else if (hstart) w_state_nxt = (LAG > 0) ? S_SKIP : S_SHIFT;
      end
      S_SKIP: begin
        if (vstart)                    w_state_nxt = S_WAIT_H;
        else if (r_cnt == c_last_skip) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (vstart)         w_state_nxt = S_WAIT_H;
        else if (w_last_px) w_state_nxt = (r_row == c_last_row) ? S_DONE : S_WAIT_H;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_en_nxt = 1'b0;
    w_addr_nxt  = wr_addr;
    w_data_nxt  = wr_data;
    w_err_nxt   = mirror_err;
    w_fd_nxt    = (r_state == S_DONE);
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    if (w_restart)  w_err_nxt = 1'b0;
    else if (w_mis) w_err_nxt = 1'b1;
    if (w_write) begin
      w_wr_en_nxt = 1'b1;
      w_addr_nxt  = r_row;
      // without mirroring the last sample is still in flight as bit 7
      w_data_nxt  = (MIRROR != 0) ? r_shift : {gfx, r_shift[6:0]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row      <= 4'd0;
      r_cnt      <= 4'd0;
      r_shift    <= 8'd0;
      wr_en      <= 1'b0;
      wr_addr    <= 4'd0;
      wr_data    <= 8'd0;
      mirror_err <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      wr_en      <= w_wr_en_nxt;
      wr_addr    <= w_addr_nxt;
      wr_data    <= w_data_nxt;
      mirror_err <= w_err_nxt;
      frame_done <= w_fd_nxt;
      busy       <= w_busy_nxt;
      if (w_restart) begin
        r_row   <= 4'd0;
        r_cnt   <= 4'd0;
        r_shift <= 8'd0;
      end else begin
        case (r_state)
          S_WAIT_H: r_cnt <= 4'd0;
          S_SKIP:   r_cnt <= (r_cnt == c_last_skip) ? 4'd0 : r_cnt + 4'd1;
          S_SHIFT: begin
            if (!r_cnt[3]) r_shift[r_cnt[2:0]] <= gfx;
            if (w_last_px) begin
              r_cnt <= 4'd0;
              if (r_row != c_last_row) r_row <= r_row + 4'd1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: r_cnt <= 4'd0;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_capture
// Brief    : Randomized self-checking bench for sprite_capture, two instances
//            (mirrored/LAG=1/16 rows and plain/LAG=0/4 rows).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_capture;

  function automatic int f_n(input int d);   return (d == 0) ? 16 : 8; endfunction
  function automatic int f_lag(input int d); return (d == 0) ? 1 : 0;  endfunction
  function automatic int f_h(input int d);   return (d == 0) ? 16 : 4; endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [1:0]      vstart, hstart, gfx;
  logic [1:0][3:0] wr_addr;
  logic [1:0][7:0] wr_data;
  logic [1:0]      wr_en, mirror_err, frame_done, busy;

  sprite_capture #(.HEIGHT(16), .MIRROR(1), .LAG(1)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .vstart(vstart[0]), .hstart(hstart[0]), .gfx(gfx[0]),
    .wr_addr(wr_addr[0]), .wr_data(wr_data[0]), .wr_en(wr_en[0]),
    .mirror_err(mirror_err[0]), .frame_done(frame_done[0]), .busy(busy[0])
  );

  sprite_capture #(.HEIGHT(4), .MIRROR(0), .LAG(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .vstart(vstart[1]), .hstart(hstart[1]), .gfx(gfx[1]),
    .wr_addr(wr_addr[1]), .wr_data(wr_data[1]), .wr_en(wr_en[1]),
    .mirror_err(mirror_err[1]), .frame_done(frame_done[1]), .busy(busy[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: current row, sticky error, last RAM write
  int         exp_row  [2];
  logic       exp_err  [2];
  logic [3:0] exp_addr [2];
  logic [7:0] exp_data [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold_chk(input int d);
    chk("addr_hold", wr_addr[d], exp_addr[d]);
    chk("data_hold", wr_data[d], exp_data[d]);
    chk("mirror_err", mirror_err[d], exp_err[d]);
    chk("fd_low", frame_done[d], 0);
  endtask

  task automatic start_frame(input int d);
    vstart[d] = 1'b1;
    tick();
    vstart[d] = 1'b0;
    exp_row[d] = 0;
    exp_err[d] = 1'b0;
    chk("vs_busy", busy[d], 1);
    chk("vs_wren", wr_en[d], 0);
    hold_chk(d);
  endtask

  task automatic send_line(input int d, input logic [15:0] px, input int abort_at,
                           input bit extra_h, output bit aborted);
    int n   = f_n(d);
    int lag = f_lag(d);
    aborted = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      gfx[d] = 1'($urandom);
      tick();
      chk("gap_wren", wr_en[d], 0);
      chk("gap_busy", busy[d], 1);
      hold_chk(d);
    end
    hstart[d] = 1'b1;
    gfx[d]    = 1'($urandom);
    tick();
    hstart[d] = 1'b0;
    chk("h_wren", wr_en[d], 0);
    for (int i = 0; i < lag; i++) begin
      gfx[d] = 1'($urandom);
      tick();
      chk("skip_wren", wr_en[d], 0);
    end
    for (int j = 0; j < n; j++) begin
      gfx[d]    = px[j];
      hstart[d] = extra_h && (j == 3);
      vstart[d] = (j == abort_at);
      tick();
      hstart[d] = 1'b0;
      vstart[d] = 1'b0;
      if (j == abort_at) begin
        exp_row[d] = 0;
        exp_err[d] = 1'b0;
        aborted    = 1'b1;
        chk("abort_wren", wr_en[d], 0);
        chk("abort_busy", busy[d], 1);
        hold_chk(d);
        return;
      end
      if (j >= 8 && px[j] != px[15 - j]) exp_err[d] = 1'b1;
      if (j == n - 1) begin
        chk("wr_en", wr_en[d], 1);
        chk("wr_addr", wr_addr[d], exp_row[d]);
        chk("wr_data", wr_data[d], px[7:0]);
        chk("mirror_err", mirror_err[d], exp_err[d]);
        exp_addr[d] = 4'(exp_row[d]);
        exp_data[d] = px[7:0];
        exp_row[d]++;
      end else begin
        chk("shift_wren", wr_en[d], 0);
        hold_chk(d);
      end
    end
  endtask

  task automatic run_frame(input int d, input bit use_fixed, input logic [7:0] fixed,
                           input int bad_row, input int bad_px,
                           input int abort_row, input int abort_px, input bit extra);
    int          r = 0;
    int          ab_row = abort_row;
    bit          ab;
    logic [15:0] px;
    logic [7:0]  b;
    start_frame(d);
    while (r < f_h(d)) begin
      b = use_fixed ? fixed : 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        px[k]      = b[k];
        px[15 - k] = b[k];
      end
      if (r == bad_row) px[bad_px] = ~px[bad_px];
      send_line(d, px, (r == ab_row) ? abort_px : -1, extra && ($urandom_range(0, 1) == 1), ab);
      if (ab) begin
        ab_row = -1;
        r = 0;
      end else begin
        r++;
      end
    end
    chk("done_busy", busy[d], 1);
    chk("done_fd_early", frame_done[d], 0);
    tick();
    chk("frame_done", frame_done[d], 1);
    chk("post_busy", busy[d], 0);
    chk("post_wren", wr_en[d], 0);
    chk("err_after_done", mirror_err[d], exp_err[d]);
    tick();
    chk("fd_pulse_end", frame_done[d], 0);
    chk("idle_busy", busy[d], 0);
    chk("err_held", mirror_err[d], exp_err[d]);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++)
      chk(tag, {wr_addr[d], wr_data[d], wr_en[d], mirror_err[d], frame_done[d], busy[d]}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          ab;
    logic [15:0] px;
    logic [7:0]  b;
    reset_n = 1'b0;
    vstart  = '0;
    hstart  = '0;
    gfx     = '0;
    for (int d = 0; d < 2; d++) begin
      exp_row[d] = 0; exp_err[d] = 1'b0; exp_addr[d] = '0; exp_data[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_outs");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_all_zero("post_reset_outs");

    // mirrored instance: clean frame, single-pixel fault, aborts, random frames
    run_frame(0, 1'b1, 8'hA5, -1, -1, -1, -1, 1'b0);
    run_frame(0, 1'b1, 8'hA5, 3, 12, -1, -1, 1'b0);
    run_frame(0, 1'b0, 8'h00, -1, -1, 5, 6, 1'b1);
    run_frame(0, 1'b0, 8'h00, $urandom_range(0, 15), $urandom_range(0, 15), 2, 15, 1'b1);
    run_frame(0, 1'b0, 8'h00, $urandom_range(0, 15), $urandom_range(0, 15), -1, -1, 1'b1);

    // plain instance
    run_frame(1, 1'b1, 8'h86, -1, -1, -1, -1, 1'b0);
    run_frame(1, 1'b0, 8'h00, 1, 9, 2, 7, 1'b1);
    for (int f = 0; f < 3; f++)
      run_frame(1, 1'b0, 8'h00, $urandom_range(0, 3), $urandom_range(0, 15),
                $urandom_range(0, 5), $urandom_range(0, 7), 1'b1);

    // reset in the middle of row 2 of a mirrored frame
    start_frame(0);
    for (int r = 0; r < 2; r++) begin
      b = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        px[k] = b[k];
        px[15 - k] = b[k];
      end
      send_line(0, px, -1, 1'b0, ab);
    end
    hstart[0] = 1'b1;
    tick();
    hstart[0] = 1'b0;
    repeat (6) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("async_reset_outs");
    for (int d = 0; d < 2; d++) begin
      exp_err[d] = 1'b0; exp_addr[d] = '0; exp_data[d] = '0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    hstart[0] = 1'b1;
    tick();
    hstart[0] = 1'b0;
    repeat (20) begin
      gfx[0] = 1'($urandom);
      tick();
      chk("no_vs_wren", wr_en[0], 0);
      chk("no_vs_busy", busy[0], 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
